latch_bank_ctrl: RTL and testbench
==================================

# latch_bank_ctrl

Write scheduler for a bank of level-sensitive D latches with active-low clear. It arbitrates write requests from NREQ requesters round-robin and sequences each write as setup, open, and hold phases so latch data is stable around every enable pulse. It also services a bank-wide clear command by driving the latches' active-low reset. It sits between the requester fabric and the latch array, and owns every latch enable, data, and clear line.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, latch data width
- DEPTH, 8, number of latch entries (need not be a power of 2)
- AW, 3, address width; 2^AW ≥ DEPTH
- SETUP_CYC, 1, cycles data is driven before enable rises (≥1)
- OPEN_CYC, 2, cycles enable is high (≥1)
- HOLD_CYC, 1, cycles data is held after enable falls (≥1)
- CLR_CYC, 2, cycles lat_reset is held low for a clear (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester write request (level)
- req_addr  in  NREQ*AW  requester i address at [i*AW +: AW]
- req_data  in  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot, 1-cycle write-complete pulse
- clr_req  in  1  bank clear request (level)
- clr_done  out  1  1-cycle clear-complete pulse
- lat_data  out  WIDTH  data to all latches
- lat_en  out  DEPTH  one-hot latch enables
- lat_reset  out  1  active-low clear to all latches
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD, CLEAR. A single down-counter times every phase.
- Arbitration happens in IDLE only.
  - clr_req has priority and moves the FSM to CLEAR.
  - Otherwise, if any req is high, the winner is the first requester at or after the rr pointer. The FSM moves to SETUP and captures the winner index, req_addr, and req_data on that edge.
  - The pointer becomes (winner+1) mod NREQ.
- SETUP: lat_data = captured data, lat_en = 0, for SETUP_CYC cycles.
- OPEN: lat_en[addr] = 1 for OPEN_CYC cycles. If addr ≥ DEPTH, lat_en stays 0 and the sequence still completes.
- HOLD: lat_en = 0 and lat_data is unchanged, for HOLD_CYC cycles. ack[winner] = 1 during the last HOLD cycle. The next state is IDLE.
- CLEAR: lat_reset = 0 and lat_en = 0 for CLR_CYC cycles. clr_done = 1 during the last CLEAR cycle. The next state is IDLE.
- Requester protocol:
  - Hold req and its addr/data stable until ack. Changes after capture are ignored.
  - To stop, drop req at the edge ending the ack cycle.
  - Keeping req high requests another write, which is granted by round-robin order.
- Clear protocol: drop clr_req at the edge ending the clr_done cycle; otherwise a new clear starts.
- lat_en, lat_data, and lat_reset come directly from flops (glitch-free into latch enables). lat_data holds its last value while idle.
- At most one lat_en bit is high at any time. lat_en and lat_reset-low are never active in the same cycle.

## Timing
- Reset values (on any edge with reset = 0): state IDLE, rr pointer 0, lat_en 0, lat_data 0, lat_reset 0 (the bank clears during reset), ack 0, clr_done 0, busy 0.
- lat_reset returns to 1 on the first edge with reset = 1.
- Reset mid-operation: aborts immediately, with no ack or clr_done for the interrupted operation.
- Write, with req seen in IDLE cycle 0:
  - SETUP in cycles 1..S.
  - OPEN in cycles S+1..S+O.
  - HOLD in cycles S+O+1..S+O+H, with ack in cycle S+O+H.
  - IDLE for at least 1 cycle.
  - Throughput: one write per 1+S+O+H cycles (5 at defaults).
- Clear: CLEAR in cycles 1..CLR_CYC, clr_done in cycle CLR_CYC, then IDLE.
- Simultaneous clr_req and req: clear first. The write is arbitrated in the IDLE cycle after the clear.

## Test plan
- **Single write** (defaults): req[2] = 1, addr = 5, data = 0xA5 in cycle 0 → lat_data = 0xA5 from cycle 1, lat_en = 0x20 in cycles 2–3, ack = 0b0100 in cycle 4, busy high in cycles 1–4.
- **Round-robin**: req = 0b1011 held high, distinct addresses → acks in order 0, 1, 3, 0, spaced 5 cycles apart; never two lat_en bits high at once.
- **Clear priority**: clr_req and req[0] both high in cycle 0 → lat_reset = 0 in cycles 1–2, clr_done in cycle 2, IDLE in cycle 3, SETUP in cycle 4, ack[0] in cycle 7.
- **Out-of-range address**: DEPTH = 6, addr = 7 → lat_en = 0 throughout, ack still in cycle 4.
- **Reset mid-write**: reset = 0 during OPEN (cycle 2) → after that edge lat_en = 0, lat_reset = 0, no ack, pointer 0. After release, a new req[1] completes normally.
- **Parameter sweep**: SETUP_CYC = 2, OPEN_CYC = 3, HOLD_CYC = 2 → lat_en high in cycles 3–5, ack in cycle 7.

Source files
------------

// File: rtl/latch_bank_ctrl.sv
// Write scheduler for a bank of level-sensitive D latches.
// Round-robin arbitration between requesters, then a setup/open/hold
// sequence around each latch enable pulse, plus a bank-wide clear.
// Every output that reaches the latch array comes straight from a flop.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | arbitrate: clear has priority, else round-robin write grant
//  SETUP | lat_data driven with captured data, all enables low
//  OPEN  | enable of the captured address high (none if out of range)
//  HOLD  | enables low, data held; ack pulses in the last cycle
//  CLEAR | lat_reset low, enables low; clr_done in the last cycle
module latch_bank_ctrl #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    input  logic                    clr_req,
    output logic                    clr_done,
    output logic [WIDTH-1:0]        lat_data,
    output logic [DEPTH-1:0]        lat_en,
    output logic                    lat_reset,
    output logic                    busy
);

    localparam int RW   = $clog2(NREQ);
    localparam int MAX1 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX2 = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
    localparam int MAXC = (MAX1 > MAX2) ? MAX1 : MAX2;
    // The counter only ever holds phase length minus one.
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CLEAR} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [RW-1:0]           rr_q;
    logic [RW-1:0]           win_q;
    logic [RW-1:0]           win_d;
    logic [RW-1:0]           rr_d;
    logic [AW-1:0]           addr_q;
    logic                    found;
    logic [DEPTH-1:0]        en_dec;
    logic [NREQ-1:0]         ack_onehot;
    logic [NREQ-1:0]         ack_q;
    logic                    clr_done_q;
    logic [WIDTH-1:0]        lat_data_q;
    logic [DEPTH-1:0]        lat_en_q;
    logic                    lat_reset_q;
    logic                    busy_q;

    // Round-robin search: first requester at or after the pointer.
    always_comb begin
        found = 1'b0;
        win_d = rr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                win_d = RW'((int'(rr_q) + k) % NREQ);
            end
        end
        rr_d = RW'((int'(win_d) + 1) % NREQ);
    end

    // Address decode; an address past the last entry enables nothing.
    always_comb begin
        en_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(addr_q) == i) en_dec[i] = 1'b1;
        end
    end

    assign ack_onehot = NREQ'(1) << win_q;

    // Sequencer: state, phase counter, and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= '0;
            win_q       <= '0;
            addr_q      <= '0;
            ack_q       <= '0;
            clr_done_q  <= 1'b0;
            lat_data_q  <= '0;
            lat_en_q    <= '0;
            lat_reset_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_q      <= '0;
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    lat_reset_q <= 1'b1;
                    lat_en_q    <= '0;
                    if (clr_req) begin
                        state_q     <= CLEAR;
                        cnt_q       <= CW'(CLR_CYC - 1);
                        lat_reset_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (CLR_CYC == 1) clr_done_q <= 1'b1;
                    end else if (found) begin
                        state_q    <= SETUP;
                        cnt_q      <= CW'(SETUP_CYC - 1);
                        win_q      <= win_d;
                        addr_q     <= req_addr[int'(win_d)*AW +: AW];
                        lat_data_q <= req_data[int'(win_d)*WIDTH +: WIDTH];
                        rr_q       <= rr_d;
                        busy_q     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q  <= OPEN;
                        cnt_q    <= CW'(OPEN_CYC - 1);
                        lat_en_q <= en_dec;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                OPEN: begin
                    if (cnt_q == '0) begin
                        state_q  <= HOLD;
                        cnt_q    <= CW'(HOLD_CYC - 1);
                        lat_en_q <= '0;
                        if (HOLD_CYC == 1) ack_q <= ack_onehot;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) ack_q <= ack_onehot;
                    end
                end
                CLEAR: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        lat_reset_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) clr_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    lat_en_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign clr_done  = clr_done_q;
    assign lat_data  = lat_data_q;
    assign lat_en    = lat_en_q;
    assign lat_reset = lat_reset_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: three instances (defaults, DEPTH=6, and
// stretched phase timing) share one stimulus. A transaction-level model
// tracks each instance by "cycles since the operation started" and is
// compared every cycle; directed literal checks pin the model.
module tb_latch_bank_ctrl;

    localparam int P_S [3] = '{1, 1, 2};
    localparam int P_O [3] = '{2, 2, 3};
    localparam int P_H [3] = '{1, 1, 2};
    localparam int P_D [3] = '{8, 6, 8};
    localparam int P_C     = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        clr_req = 1'b0;

    logic [3:0]  ack0, ack1, ack2;
    logic        done0, done1, done2;
    logic [7:0]  dat0, dat1, dat2;
    logic [7:0]  en0, en2;
    logic [5:0]  en1;
    logic        lrst0, lrst1, lrst2;
    logic        busy0, busy1, busy2;

    logic [3:0]  o_ack [3];
    logic        o_done [3];
    logic [7:0]  o_dat [3];
    logic [7:0]  o_en [3];
    logic        o_lrst [3];
    logic        o_busy [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    latch_bank_ctrl u0 (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack0), .clr_req(clr_req), .clr_done(done0), .lat_data(dat0),
        .lat_en(en0), .lat_reset(lrst0), .busy(busy0));

    latch_bank_ctrl #(.DEPTH(6)) u1 (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack1), .clr_req(clr_req), .clr_done(done1), .lat_data(dat1),
        .lat_en(en1), .lat_reset(lrst1), .busy(busy1));

    latch_bank_ctrl #(.SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u2 (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack2), .clr_req(clr_req), .clr_done(done2), .lat_data(dat2),
        .lat_en(en2), .lat_reset(lrst2), .busy(busy2));

    assign o_ack[0] = ack0;   assign o_ack[1] = ack1;   assign o_ack[2] = ack2;
    assign o_done[0] = done0; assign o_done[1] = done1; assign o_done[2] = done2;
    assign o_dat[0] = dat0;   assign o_dat[1] = dat1;   assign o_dat[2] = dat2;
    assign o_en[0] = en0;     assign o_en[1] = {2'b00, en1}; assign o_en[2] = en2;
    assign o_lrst[0] = lrst0; assign o_lrst[1] = lrst1; assign o_lrst[2] = lrst2;
    assign o_busy[0] = busy0; assign o_busy[1] = busy1; assign o_busy[2] = busy2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: kind 0 idle, 1 write, 2 clear; t counts cycles into the operation.
    int         m_kind [3];
    int         m_t [3];
    int         m_win [3];
    int         m_addr [3];
    int         m_rr [3];
    logic [7:0] m_data [3];
    bit         m_rst [3];
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (!reset) begin
                m_kind[n] = 0; m_rr[n] = 0; m_data[n] = 8'h00; m_rst[n] = 1'b1;
            end else begin
                m_rst[n] = 1'b0;
                if (m_kind[n] == 0) begin
                    if (clr_req) begin
                        m_kind[n] = 2; m_t[n] = 1;
                    end else if (req != 4'b0) begin
                        for (int k = 0; k < 4; k++) begin
                            if (m_kind[n] == 0 && req[(m_rr[n] + k) % 4]) begin
                                m_win[n]  = (m_rr[n] + k) % 4;
                                m_kind[n] = 1;
                            end
                        end
                        m_addr[n] = int'(req_addr[m_win[n]*3 +: 3]);
                        m_data[n] = req_data[m_win[n]*8 +: 8];
                        m_rr[n]   = (m_win[n] + 1) % 4;
                        m_t[n]    = 1;
                    end
                end else begin
                    m_t[n]++;
                    if (m_t[n] > ((m_kind[n] == 1) ? P_S[n] + P_O[n] + P_H[n] : P_C))
                        m_kind[n] = 0;
                end
            end
        end
        model_valid = 1'b1;
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int n = 0; n < 3; n++) begin
                logic [7:0] e_en;
                logic [3:0] e_ack;
                logic       e_done;
                e_en = '0; e_ack = '0; e_done = 1'b0;
                if (m_kind[n] == 1) begin
                    if (m_t[n] > P_S[n] && m_t[n] <= P_S[n] + P_O[n] && m_addr[n] < P_D[n])
                        e_en = 8'(1) << m_addr[n];
                    if (m_t[n] == P_S[n] + P_O[n] + P_H[n])
                        e_ack = 4'(1) << m_win[n];
                end
                if (m_kind[n] == 2 && m_t[n] == P_C) e_done = 1'b1;
                chk($sformatf("u%0d_lat_en", n), 32'(o_en[n]), 32'(e_en));
                chk($sformatf("u%0d_ack", n), 32'(o_ack[n]), 32'(e_ack));
                chk($sformatf("u%0d_clr_done", n), 32'(o_done[n]), 32'(e_done));
                chk($sformatf("u%0d_lat_data", n), 32'(o_dat[n]), 32'(m_data[n]));
                chk($sformatf("u%0d_lat_reset", n), 32'(o_lrst[n]),
                    32'(!(m_rst[n] || m_kind[n] == 2)));
                chk($sformatf("u%0d_busy", n), 32'(o_busy[n]), 32'(m_kind[n] != 0));
                chk($sformatf("u%0d_en_onehot", n), 32'($countones(o_en[n]) <= 1), 32'(1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic drain(input int cycles);
        req = '0; clr_req = 1'b0;
        repeat (cycles) step();
    endtask

    // Single write from requester 2: literal timing for all three instances.
    task automatic write_test(input logic [2:0] a, input logic [7:0] d);
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) begin set_slot(2, a, d); req = 4'b0100; end
            if (c == 1) req = '0;
            @(negedge clk);
            chk("wr_u0_en", 32'(en0), ((c == 2 || c == 3)) ? 32'(8'(1) << a) : 32'h0);
            chk("wr_u1_en", 32'(en1), ((c == 2 || c == 3) && a < 3'd6) ? 32'(6'(1) << a) : 32'h0);
            chk("wr_u2_en", 32'(en2), ((c >= 3 && c <= 5)) ? 32'(8'(1) << a) : 32'h0);
            chk("wr_u0_ack", 32'(ack0), (c == 4) ? 32'h4 : 32'h0);
            chk("wr_u1_ack", 32'(ack1), (c == 4) ? 32'h4 : 32'h0);
            chk("wr_u2_ack", 32'(ack2), (c == 7) ? 32'h4 : 32'h0);
            chk("wr_u0_busy", 32'(busy0), (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            if (c >= 1) chk("wr_u0_data", 32'(dat0), 32'(d));
            step();
        end
    endtask

    // Single-cycle request; u0 must ack the named requester 4 cycles later.
    task automatic grant_test(input logic [3:0] r, input logic [3:0] exp_ack);
        for (int c = 0; c <= 10; c++) begin
            if (c == 0) req = r;
            if (c == 1) req = '0;
            @(negedge clk);
            chk("grant_u0_ack", 32'(ack0), (c == 4) ? 32'(exp_ack) : 32'h0);
            step();
        end
    endtask

    initial begin
        set_slot(0, 3'd1, 8'h11);
        set_slot(1, 3'd2, 8'h22);
        set_slot(2, 3'd5, 8'h33);
        set_slot(3, 3'd4, 8'h44);
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_lat_reset", 32'(lrst0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_lat_data", 32'(dat0), 32'h0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("rel_lat_reset", 32'(lrst0), 32'h1);
        step();

        // Round-robin with requesters 0, 1, 3 held high.
        req = 4'b1011;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("rr_u0_ack", 32'(ack0),
                (c == 4) ? 32'h1 : (c == 9) ? 32'h2 : (c == 14) ? 32'h8 : (c == 19) ? 32'h1 : 32'h0);
            step();
        end
        drain(15);

        write_test(3'd5, 8'hA5);
        drain(3);
        write_test(3'd7, 8'h3C);
        drain(3);

        // Clear has priority over a simultaneous write request.
        set_slot(0, 3'd1, 8'h5E);
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) begin clr_req = 1'b1; req = 4'b0001; end
            if (c == 3) clr_req = 1'b0;
            if (c == 8) req = '0;
            @(negedge clk);
            chk("clr_u0_lat_reset", 32'(lrst0), (c == 1 || c == 2) ? 32'h0 : 32'h1);
            chk("clr_u0_done", 32'(done0), (c == 2) ? 32'h1 : 32'h0);
            chk("clr_u0_busy", 32'(busy0), (c == 1 || c == 2 || (c >= 4 && c <= 7)) ? 32'h1 : 32'h0);
            chk("clr_u0_en", 32'(en0), (c == 5 || c == 6) ? 32'h2 : 32'h0);
            chk("clr_u0_ack", 32'(ack0), (c == 7) ? 32'h1 : 32'h0);
            step();
        end
        drain(12);

        // Reset during OPEN aborts the write.
        set_slot(1, 3'd3, 8'h5A);
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) req = 4'b0010;
            if (c == 1) req = '0;
            if (c == 2) reset = 1'b0;
            if (c == 3) reset = 1'b1;
            @(negedge clk);
            if (c == 2) chk("mid_u0_en_open", 32'(en0), 32'h8);
            if (c == 3) begin
                chk("mid_u0_en", 32'(en0), 32'h0);
                chk("mid_u0_lat_reset", 32'(lrst0), 32'h0);
                chk("mid_u0_busy", 32'(busy0), 32'h0);
            end
            if (c == 4) chk("mid_u0_lat_reset_rel", 32'(lrst0), 32'h1);
            chk("mid_u0_ack", 32'(ack0), 32'h0);
            step();
        end
        // Pointer is back at 0, so requester 0 beats requester 2.
        grant_test(4'b0101, 4'b0001);
        drain(2);
        grant_test(4'b0010, 4'b0010);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
